// File: rtl/aes_key_expand128.sv
// aes_key_expand128: on-the-fly AES-128 key schedule with one shared byte S-box stepped over four cycles
module aes_key_expand128 #(
  parameter int NUM_ROUNDS  = 10,
  parameter int SBOX_CYCLES = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic [127:0] key_i,
  input  logic         next_i,
  output logic [127:0] round_key_o,
  output logic [3:0]   round_idx_o,
  output logic         key_valid_o,
  output logic         zero_round_o,
  output logic         final_round_o,
  output logic         busy_o,
  output logic         done_o
);
  typedef enum logic [1:0] {IDLE, VALID, SUB, COMBINE} state_t;
  localparam logic [3:0] last_idx = 4'(NUM_ROUNDS);
  localparam logic [1:0] last_b   = 2'(SBOX_CYCLES - 1);
  localparam logic [0:255][7:0] sbox_tab = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  state_t       state, state_d;
  logic [1:0]   b;
  logic [7:0]   rcon, rcon_next, sbox_out;
  logic [31:0]  temp, rot_sh, w0n, w1n, w2n, w3n;
  logic         last_key;
  assign last_key  = round_idx_o == last_idx;
  // byte b of RotWord(w3) is brought to the top byte so one S-box port serves all four bytes
  assign rot_sh    = {round_key_o[23:0], round_key_o[31:24]} << {b, 3'b000};
  assign sbox_out  = sbox_tab[rot_sh[31:24]];
  assign rcon_next = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
  assign w0n = round_key_o[127:96] ^ temp ^ {rcon, 24'h0};
  assign w1n = round_key_o[95:64] ^ w0n;
  assign w2n = round_key_o[63:32] ^ w1n;
  assign w3n = round_key_o[31:0] ^ w2n;
  assign key_valid_o   = state == VALID;
  assign busy_o        = state != IDLE;
  assign zero_round_o  = key_valid_o && round_idx_o == 4'd0;
  assign final_round_o = key_valid_o && last_key;
  always_comb begin
    state_d = state;
    state_d = state == IDLE  ? (start_i ? VALID : IDLE) :
              state == VALID ? (next_i ? (last_key ? IDLE : SUB) : VALID) :
              state == SUB   ? (b == last_b ? COMBINE : SUB) : VALID;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else state <= state_d;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      round_key_o <= '0;
      round_idx_o <= '0;
      rcon        <= 8'h01;
      b           <= '0;
      temp        <= '0;
      done_o      <= 1'b0;
    end else begin
      done_o <= state == VALID && next_i && last_key;
      if (state == IDLE && start_i) begin
        round_key_o <= key_i;
        round_idx_o <= '0;
        rcon        <= 8'h01;
      end
      if (state == SUB) begin
        temp <= {temp[23:0], sbox_out};
        b    <= b + 2'd1;
      end
      if (state == COMBINE) begin
        round_key_o <= {w0n, w1n, w2n, w3n};
        round_idx_o <= round_idx_o + 4'd1;
        rcon        <= rcon_next;
      end
    end
  end
endmodule
